framebuf_multi: RTL and testbench
=================================

# framebuf_multi

Parametrised multi-buffered frame store between the core's pixel writer (`color_ready`/`hh`/`vv` stream) and the video scan-out side in the emu top level. It holds N_BUF complete frames in block RAM, gives the core an exclusive write buffer and the video side an exclusive read buffer, and rotates them only at the start of read-side vertical blank so scan-out never tears. Compared with the inline double buffer it replaces, it adds:

- Fully synchronous swap logic with edge detection on `frame_done`, instead of clocking on `frame`.
- Optional triple buffering.
- Optional hardware clear of each new write buffer.
- An overrun counter.

## Interface

Parameters:
- `H_BITS`, 8: horizontal address bits; line width is 2^H_BITS.
- `V_BITS`, 8: vertical address bits; frame height is 2^V_BITS.
- `PIX_W`, 8: pixel word width.
- `N_BUF`, 2: number of buffers; legal values are 2 or 3.
- `CLEAR_EN`, 0: when 1, each new write buffer is filled with `CLEAR_VAL` before the core uses it.
- `CLEAR_VAL`, 0: fill value, `PIX_W` bits wide.

Ports:
- `clk_sys`  in  1  sole clock; every register and the RAM use it.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  pixel write strobe from the core.
- `wr_h`  in  H_BITS  write column.
- `wr_v`  in  V_BITS  write row.
- `wr_pix`  in  PIX_W  write data.
- `frame_done`  in  1  level signal from the core; a rising edge marks the write frame as complete.
- `vblank`  in  1  read-side vertical blank; swaps take effect on its rising edge.
- `rd_en`  in  1  read strobe from the video side (display enable).
- `rd_h`  in  H_BITS  read column.
- `rd_v`  in  V_BITS  read row.
- `rd_pix`  out  PIX_W  registered read data.
- `wr_buf`  out  2  index of the current write buffer.
- `rd_buf`  out  2  index of the current read buffer.
- `wr_busy`  out  1  clear sweep in progress; `wr_en` is ignored while high.
- `overrun_cnt`  out  8  saturating count of completed frames lost or overwritten before display.

## Operation

- Addressing: RAM depth is N_BUF·2^(H_BITS+V_BITS). A word address is buf·2^(H+V) + v·2^H + h, formed by concatenation `{buf, v, h}`.
- Write port: when `wr_en` is high and `wr_busy` is low, `wr_pix` is written to `{wr_buf, wr_v, wr_h}`.
- Read port: when `rd_en` is high, `rd_pix` loads from `{rd_buf, rd_v, rd_h}`. When `rd_en` is low, `rd_pix` holds its value.
- Edge detection: `fd_rise = frame_done & ~frame_done_q` and `vb_rise = vblank & ~vblank_q`, both registered in `clk_sys`.
- `wr_buf` is never equal to `rd_buf`.

N_BUF = 2:
- `fd_rise` sets `pending`.
- If `fd_rise` arrives while `pending` is already 1, `overrun_cnt` increments.
- `vb_rise` with `pending` set swaps `wr_buf` and `rd_buf` and clears `pending`.
- `vb_rise` with `pending` clear does nothing.

N_BUF = 3 (write, ready and read indices; free = 3 − wr − rd):
- On `fd_rise`: ready ← wr, wr ← free buffer (the old ready if one was valid), `rdy_valid` ← 1.
- If `rdy_valid` was already 1 on `fd_rise`, the old ready frame is discarded and `overrun_cnt` increments.
- On `vb_rise` with `rdy_valid` set: rd ← ready, `rdy_valid` ← 0.

Simultaneous `fd_rise` and `vb_rise` in the same cycle:
- N_BUF = 2: treated as pending, so the swap happens that cycle.
- N_BUF = 3: the `fd_rise` update is applied first, then the new ready buffer is promoted in the same cycle. Net result: rd ← old wr, wr ← free buffer.

Clear (only when `CLEAR_EN` = 1):
- Starts whenever `wr_buf` changes.
- Sweeps h/v from 0 to 2^(H+V)−1, one word per cycle, writing `CLEAR_VAL`.
- `wr_busy` is high for exactly 2^(H+V) cycles.
- If `wr_buf` changes during a sweep, the sweep restarts at address 0 on the new buffer.
- The sweep writes only to `wr_buf`, never to `rd_buf`.

Counter:
- `overrun_cnt` saturates at 255.

## Timing

- Reset values:
  - `wr_buf` = 0, `rd_buf` = 1.
  - `pending` = 0, `rdy_valid` = 0.
  - `rd_pix` = 0, `wr_busy` = 0, `overrun_cnt` = 0.
  - Edge registers = 0.
  - RAM contents are undefined.
- Reset during a clear sweep aborts the sweep immediately.
- Write latency: the data is in RAM at the edge where `wr_en` is sampled. It is readable once that buffer becomes the read buffer.
- Read latency: 1 cycle. `rd_pix` is valid on the cycle after the `rd_en`/address cycle.
- Swap: `rd_buf`/`wr_buf` update on the edge where `vb_rise` is computed, i.e. 2 edges after `vblank` rises. A read issued in that same cycle uses the old `rd_buf`.
- N_BUF = 3: `wr_buf` changes 2 edges after `frame_done` rises.
- `wr_busy` rises on the cycle after `wr_buf` changes. Clear completes 2^(H+V) cycles later.
- A `wr_en` that coincides with the `wr_buf` change is written to the old buffer.

## Test plan

- **Reset and basic read:** Reset, default parameters. Write 0xA5 to (h=3, v=7) → no change at `rd_buf`=1 (the write went to buffer 0). Then raise `frame_done`, then `vblank` → `rd_buf`=0, `wr_buf`=1; reading (3,7) returns 0xA5 one cycle after `rd_en`.
- **Double-buffer overrun:** N_BUF=2. Two `frame_done` rising edges with no `vblank` between them → `overrun_cnt`=1, buffers unswapped. Next `vblank` edge → exactly one swap; `pending`=0.
- **Triple-buffer hand-off:** N_BUF=3. First `frame_done` → `wr_buf`=2, ready=0. Second `frame_done` → ready=2, `wr_buf`=0, `overrun_cnt`=1. Then `vblank` → `rd_buf`=2; `wr_buf`≠`rd_buf` throughout.
- **Simultaneous edges:** `frame_done` and `vblank` rise in the same cycle, both N_BUF values → swap occurs in that cycle. For N_BUF=3 the result is `rd_buf` = old `wr_buf`.
- **Clear sweep:** CLEAR_EN=1, H_BITS=V_BITS=4, CLEAR_VAL=0x3C. Trigger a swap → `wr_busy` is high for exactly 256 cycles; `wr_en` pulses during the sweep leave no trace; after the next swap every word reads 0x3C. Assert reset mid-sweep → `wr_busy`=0 on the next cycle.
- **Counter saturation:** 300 overrun events → `overrun_cnt` holds at 255.

Source files
------------

// File: rtl/framebuf_multi.sv
// Multi-buffered frame store: core writes one buffer while video scans out another;
// buffers rotate only on read-side vblank so scan-out never tears.
module framebuf_multi #(
  parameter int unsigned       H_BITS    = 8,
  parameter int unsigned       V_BITS    = 8,
  parameter int unsigned       PIX_W     = 8,
  parameter int unsigned       N_BUF     = 2,
  parameter int unsigned       CLEAR_EN  = 0,
  parameter logic [PIX_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [H_BITS-1:0] wr_h,
  input  logic [V_BITS-1:0] wr_v,
  input  logic [PIX_W-1:0]  wr_pix,
  input  logic              frame_done,
  input  logic              vblank,
  input  logic              rd_en,
  input  logic [H_BITS-1:0] rd_h,
  input  logic [V_BITS-1:0] rd_v,
  output logic [PIX_W-1:0]  rd_pix,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              wr_busy,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned PIX_AW = H_BITS + V_BITS;
  localparam int unsigned BUF_W  = (N_BUF > 2) ? 2 : 1;
  localparam int unsigned ADDR_W = BUF_W + PIX_AW;
  localparam int unsigned DEPTH  = N_BUF * (2 ** PIX_AW);

  logic [PIX_W-1:0]  r_mem [0:DEPTH-1];
  logic [PIX_W-1:0]  r_rd_pix;

  logic              r_fd_q;
  logic              r_vb_q;
  logic              r_fd_rise;
  logic              r_vb_rise;

  logic [1:0]        r_wr_buf;
  logic [1:0]        r_rd_buf;
  logic [1:0]        r_rdy_buf;
  logic              r_pending;
  logic              r_rdy_valid;
  logic [7:0]        r_ovr_cnt;

  logic [1:0]        r_wr_buf_q;
  logic              r_busy;
  logic [PIX_AW-1:0] r_clr_cnt;

  logic [1:0]        w_free;
  logic [1:0]        w_wr_nxt;
  logic [1:0]        w_rd_nxt;
  logic [1:0]        w_rdy_nxt;
  logic              w_pend_nxt;
  logic              w_rdyv_nxt;
  logic              w_lost;
  logic              w_buf_chg;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [PIX_W-1:0]  w_wdata;

  // Registered edge detectors for the frame-complete and vblank levels
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_fd_q    <= 1'b0;
      r_vb_q    <= 1'b0;
      r_fd_rise <= 1'b0;
      r_vb_rise <= 1'b0;
    end else begin
      r_fd_q    <= frame_done;
      r_vb_q    <= vblank;
      r_fd_rise <= frame_done & ~r_fd_q;
      r_vb_rise <= vblank & ~r_vb_q;
    end
  end

  assign w_free = 2'd3 - r_wr_buf - r_rd_buf;

  // Buffer rotation; the frame-done update is applied before vblank promotion
  always_comb begin
    w_wr_nxt   = r_wr_buf;
    w_rd_nxt   = r_rd_buf;
    w_rdy_nxt  = r_rdy_buf;
    w_pend_nxt = r_pending;
    w_rdyv_nxt = r_rdy_valid;
    w_lost     = 1'b0;
    if (N_BUF > 2) begin
      if (r_fd_rise) begin
        w_rdy_nxt  = r_wr_buf;
        w_wr_nxt   = w_free;
        w_rdyv_nxt = 1'b1;
        w_lost     = r_rdy_valid;
      end
      if (r_vb_rise && w_rdyv_nxt) begin
        w_rd_nxt   = w_rdy_nxt;
        w_rdyv_nxt = 1'b0;
      end
    end else begin
      if (r_fd_rise) begin
        w_pend_nxt = 1'b1;
        w_lost     = r_pending;
      end
      if (r_vb_rise && w_pend_nxt) begin
        w_wr_nxt   = r_rd_buf;
        w_rd_nxt   = r_wr_buf;
        w_pend_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_buf    <= 2'd0;
      r_rd_buf    <= 2'd1;
      r_rdy_buf   <= 2'd2;
      r_pending   <= 1'b0;
      r_rdy_valid <= 1'b0;
      r_ovr_cnt   <= 8'd0;
    end else begin
      r_wr_buf    <= w_wr_nxt;
      r_rd_buf    <= w_rd_nxt;
      r_rdy_buf   <= w_rdy_nxt;
      r_pending   <= w_pend_nxt;
      r_rdy_valid <= w_rdyv_nxt;
      if (w_lost && (r_ovr_cnt != 8'hFF)) begin
        r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
    end
  end

  assign w_buf_chg = (r_wr_buf != r_wr_buf_q);

  // Clear sweep of each newly assigned write buffer; restarts on another change
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_buf_q <= 2'd0;
      r_busy     <= 1'b0;
      r_clr_cnt  <= '0;
    end else begin
      r_wr_buf_q <= r_wr_buf;
      if (CLEAR_EN != 0) begin
        if (w_buf_chg) begin
          r_busy    <= 1'b1;
          r_clr_cnt <= '0;
        end else if (r_busy) begin
          r_clr_cnt <= r_clr_cnt + PIX_AW'(1);
          if (r_clr_cnt == '1) begin
            r_busy <= 1'b0;
          end
        end
      end
    end
  end

  assign w_we      = r_busy | wr_en;
  assign w_wdata   = r_busy ? CLEAR_VAL : wr_pix;
  assign w_wr_addr = r_busy ? {r_wr_buf[BUF_W-1:0], r_clr_cnt}
                            : {r_wr_buf[BUF_W-1:0], wr_v, wr_h};
  assign w_rd_addr = {r_rd_buf[BUF_W-1:0], rd_v, rd_h};

  always_ff @(posedge clk_sys) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rd_pix <= '0;
    end else if (rd_en) begin
      r_rd_pix <= r_mem[w_rd_addr];
    end
  end

  assign rd_pix      = r_rd_pix;
  assign wr_buf      = r_wr_buf;
  assign rd_buf      = r_rd_buf;
  assign wr_busy     = r_busy;
  assign overrun_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_framebuf_multi.sv
// Directed bench for framebuf_multi: double, triple and clear-enabled instances.
module tb_framebuf_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: double buffer, default geometry
  logic       a_wr_en, a_fd, a_vb, a_rd_en;
  logic [7:0] a_wr_h, a_wr_v, a_wr_pix, a_rd_h, a_rd_v;
  logic [7:0] a_rd_pix, a_ovr;
  logic [1:0] a_wr_buf, a_rd_buf;
  logic       a_busy;

  // Instance B: triple buffer, 16x16
  logic       b_wr_en, b_fd, b_vb, b_rd_en;
  logic [3:0] b_wr_h, b_wr_v, b_rd_h, b_rd_v;
  logic [7:0] b_wr_pix, b_rd_pix, b_ovr;
  logic [1:0] b_wr_buf, b_rd_buf;
  logic       b_busy;

  // Instance C: double buffer with hardware clear, 16x16
  logic       c_wr_en, c_fd, c_vb, c_rd_en;
  logic [3:0] c_wr_h, c_wr_v, c_rd_h, c_rd_v;
  logic [7:0] c_wr_pix, c_rd_pix, c_ovr;
  logic [1:0] c_wr_buf, c_rd_buf;
  logic       c_busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  framebuf_multi #(.H_BITS(8), .V_BITS(8), .PIX_W(8), .N_BUF(2),
                   .CLEAR_EN(0), .CLEAR_VAL(8'h00)) u_a (
    .clk_sys(clk), .reset(reset), .wr_en(a_wr_en), .wr_h(a_wr_h), .wr_v(a_wr_v),
    .wr_pix(a_wr_pix), .frame_done(a_fd), .vblank(a_vb), .rd_en(a_rd_en),
    .rd_h(a_rd_h), .rd_v(a_rd_v), .rd_pix(a_rd_pix), .wr_buf(a_wr_buf),
    .rd_buf(a_rd_buf), .wr_busy(a_busy), .overrun_cnt(a_ovr));

  framebuf_multi #(.H_BITS(4), .V_BITS(4), .PIX_W(8), .N_BUF(3),
                   .CLEAR_EN(0), .CLEAR_VAL(8'h00)) u_b (
    .clk_sys(clk), .reset(reset), .wr_en(b_wr_en), .wr_h(b_wr_h), .wr_v(b_wr_v),
    .wr_pix(b_wr_pix), .frame_done(b_fd), .vblank(b_vb), .rd_en(b_rd_en),
    .rd_h(b_rd_h), .rd_v(b_rd_v), .rd_pix(b_rd_pix), .wr_buf(b_wr_buf),
    .rd_buf(b_rd_buf), .wr_busy(b_busy), .overrun_cnt(b_ovr));

  framebuf_multi #(.H_BITS(4), .V_BITS(4), .PIX_W(8), .N_BUF(2),
                   .CLEAR_EN(1), .CLEAR_VAL(8'h3C)) u_c (
    .clk_sys(clk), .reset(reset), .wr_en(c_wr_en), .wr_h(c_wr_h), .wr_v(c_wr_v),
    .wr_pix(c_wr_pix), .frame_done(c_fd), .vblank(c_vb), .rd_en(c_rd_en),
    .rd_h(c_rd_h), .rd_v(c_rd_v), .rd_pix(c_rd_pix), .wr_buf(c_wr_buf),
    .rd_buf(c_rd_buf), .wr_busy(c_busy), .overrun_cnt(c_ovr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [7:0] h, input logic [7:0] v, input logic [7:0] p);
    a_wr_en = 1'b1; a_wr_h = h; a_wr_v = v; a_wr_pix = p;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] h, input logic [3:0] v, input logic [7:0] p);
    b_wr_en = 1'b1; b_wr_h = h; b_wr_v = v; b_wr_pix = p;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [7:0] h, input logic [7:0] v,
                      input logic [7:0] exp);
    logic [7:0] e;
    a_rd_en = 1'b1; a_rd_h = h; a_rd_v = v;
    exp_q.push_back(exp);
    tick();
    a_rd_en = 1'b0;
    e = exp_q.pop_front();
    chk(tag, 32'(a_rd_pix), 32'(e));
  endtask

  task automatic rd_b(input string tag, input logic [3:0] h, input logic [3:0] v,
                      input logic [7:0] exp);
    logic [7:0] e;
    b_rd_en = 1'b1; b_rd_h = h; b_rd_v = v;
    exp_q.push_back(exp);
    tick();
    b_rd_en = 1'b0;
    e = exp_q.pop_front();
    chk(tag, 32'(b_rd_pix), 32'(e));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    logic [7:0] e;

    reset = 1'b1;
    a_wr_en = 0; a_fd = 0; a_vb = 0; a_rd_en = 0;
    a_wr_h = 0; a_wr_v = 0; a_wr_pix = 0; a_rd_h = 0; a_rd_v = 0;
    b_wr_en = 0; b_fd = 0; b_vb = 0; b_rd_en = 0;
    b_wr_h = 0; b_wr_v = 0; b_wr_pix = 0; b_rd_h = 0; b_rd_v = 0;
    c_wr_en = 0; c_fd = 0; c_vb = 0; c_rd_en = 0;
    c_wr_h = 0; c_wr_v = 0; c_wr_pix = 0; c_rd_h = 0; c_rd_v = 0;
    tick(); tick();

    // Reset state
    chk("rst_a_wr_buf", 32'(a_wr_buf), 32'd0);
    chk("rst_a_rd_buf", 32'(a_rd_buf), 32'd1);
    chk("rst_a_rd_pix", 32'(a_rd_pix), 32'd0);
    chk("rst_a_ovr",    32'(a_ovr),    32'd0);
    chk("rst_b_wr_buf", 32'(b_wr_buf), 32'd0);
    chk("rst_b_rd_buf", 32'(b_rd_buf), 32'd1);
    chk("rst_c_busy",   32'(c_busy),   32'd0);
    reset = 1'b0;
    tick();

    // A: write to buffer 0, then frame_done and vblank swap
    wr_a(8'd3, 8'd7, 8'hA5);
    chk("a_no_swap_after_write", 32'(a_rd_buf), 32'd1);
    a_fd = 1'b1; tick(); tick(); a_fd = 1'b0; tick();
    chk("a_pending_no_swap", 32'(a_rd_buf), 32'd1);
    a_vb = 1'b1; tick();
    chk("a_swap_not_yet", 32'(a_rd_buf), 32'd1);
    tick();
    chk("a_swap_rd_buf", 32'(a_rd_buf), 32'd0);
    chk("a_swap_wr_buf", 32'(a_wr_buf), 32'd1);
    a_vb = 1'b0; tick();
    rd_a("a_read_a5", 8'd3, 8'd7, 8'hA5);
    a_rd_h = 8'd0; a_rd_v = 8'd0; tick();
    chk("a_rd_pix_hold", 32'(a_rd_pix), 32'hA5);

    // A: fill buffer 1, then two frame_done edges without vblank
    wr_a(8'd3, 8'd7, 8'h5A);
    wr_a(8'd255, 8'd255, 8'h77);
    a_fd = 1'b1; tick(); tick(); a_fd = 1'b0; tick();
    a_fd = 1'b1; tick(); tick(); a_fd = 1'b0; tick();
    chk("a_overrun_one", 32'(a_ovr), 32'd1);
    chk("a_overrun_unswapped", 32'(a_rd_buf), 32'd0);
    a_vb = 1'b1; tick(); tick(); a_vb = 1'b0; tick();
    chk("a_one_swap_rd", 32'(a_rd_buf), 32'd1);
    a_vb = 1'b1; tick(); tick(); a_vb = 1'b0; tick();
    chk("a_no_second_swap_rd", 32'(a_rd_buf), 32'd1);
    chk("a_no_second_swap_wr", 32'(a_wr_buf), 32'd0);
    rd_a("a_read_5a", 8'd3, 8'd7, 8'h5A);
    rd_a("a_read_corner", 8'd255, 8'd255, 8'h77);

    // A: simultaneous frame_done and vblank edges
    a_fd = 1'b1; a_vb = 1'b1; tick(); tick();
    chk("a_simul_rd", 32'(a_rd_buf), 32'd0);
    chk("a_simul_wr", 32'(a_wr_buf), 32'd1);
    a_fd = 1'b0; a_vb = 1'b0; tick();
    chk("a_simul_no_ovr", 32'(a_ovr), 32'd1);

    // A: overrun counter saturation
    for (int k = 0; k < 254; k++) begin
      a_fd = 1'b1; tick(); a_fd = 1'b0; tick();
    end
    tick(); tick();
    chk("a_ovr_254", 32'(a_ovr), 32'd254);
    a_fd = 1'b1; tick(); a_fd = 1'b0; tick(); tick(); tick();
    chk("a_ovr_255", 32'(a_ovr), 32'd255);
    for (int k = 0; k < 45; k++) begin
      a_fd = 1'b1; tick(); a_fd = 1'b0; tick();
    end
    tick(); tick();
    chk("a_ovr_saturated", 32'(a_ovr), 32'd255);

    // B: triple-buffer hand-off
    wr_b(4'd2, 4'd2, 8'h11);
    b_fd = 1'b1; tick();
    chk("b_wr_not_yet", 32'(b_wr_buf), 32'd0);
    tick();
    chk("b_fd1_wr_buf", 32'(b_wr_buf), 32'd2);
    chk("b_fd1_rd_buf", 32'(b_rd_buf), 32'd1);
    chk("b_fd1_distinct", 32'(b_wr_buf != b_rd_buf), 32'd1);
    b_fd = 1'b0; tick();
    wr_b(4'd2, 4'd2, 8'h22);
    b_fd = 1'b1; tick(); tick(); b_fd = 1'b0; tick();
    chk("b_fd2_wr_buf", 32'(b_wr_buf), 32'd0);
    chk("b_fd2_ovr", 32'(b_ovr), 32'd1);
    chk("b_fd2_distinct", 32'(b_wr_buf != b_rd_buf), 32'd1);
    b_vb = 1'b1; tick(); tick(); b_vb = 1'b0; tick();
    chk("b_vb_rd_buf", 32'(b_rd_buf), 32'd2);
    chk("b_vb_wr_buf", 32'(b_wr_buf), 32'd0);
    rd_b("b_read_22", 4'd2, 4'd2, 8'h22);

    // B: simultaneous edges promote the old write buffer directly
    wr_b(4'd2, 4'd2, 8'h33);
    b_fd = 1'b1; b_vb = 1'b1; tick(); tick();
    chk("b_simul_rd", 32'(b_rd_buf), 32'd0);
    chk("b_simul_wr", 32'(b_wr_buf), 32'd1);
    b_fd = 1'b0; b_vb = 1'b0; tick();
    chk("b_simul_ovr", 32'(b_ovr), 32'd1);
    rd_b("b_read_33", 4'd2, 4'd2, 8'h33);

    // C: clear sweep length, wr_en ignored while busy
    c_fd = 1'b1; c_vb = 1'b1; tick(); tick();
    c_fd = 1'b0; c_vb = 1'b0;
    chk("c_swap_wr", 32'(c_wr_buf), 32'd1);
    chk("c_busy_not_yet", 32'(c_busy), 32'd0);
    busy_n = 0;
    for (int k = 0; k < 300; k++) begin
      if (c_busy) begin
        busy_n++;
        if ((k >= 16) && (k % 16 == 3)) begin
          c_wr_en = 1'b1; c_wr_h = 4'(k - 10); c_wr_v = 4'((k - 10) >> 4);
          c_wr_pix = 8'hEE;
        end
      end
      tick();
      c_wr_en = 1'b0;
    end
    chk("c_busy_cycles", 32'(busy_n), 32'd256);
    chk("c_busy_done", 32'(c_busy), 32'd0);

    // C: show the cleared buffer and read every word
    c_fd = 1'b1; c_vb = 1'b1; tick(); tick();
    c_fd = 1'b0; c_vb = 1'b0;
    chk("c_swap2_rd", 32'(c_rd_buf), 32'd1);
    for (int i = 0; i < 256; i++) begin
      c_rd_en = 1'b1; c_rd_h = 4'(i); c_rd_v = 4'(i >> 4);
      exp_q.push_back(8'h3C);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("c_clear_word_%0d", i), 32'(c_rd_pix), 32'(e));
    end
    c_rd_en = 1'b0;

    // C: reset mid-sweep aborts it
    c_fd = 1'b1; c_vb = 1'b1; tick(); tick();
    c_fd = 1'b0; c_vb = 1'b0;
    repeat (10) tick();
    chk("c_busy_mid_sweep", 32'(c_busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("c_rst_busy", 32'(c_busy), 32'd0);
    chk("c_rst_wr_buf", 32'(c_wr_buf), 32'd0);
    chk("c_rst_rd_buf", 32'(c_rd_buf), 32'd1);
    chk("a_rst_ovr", 32'(a_ovr), 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("c_busy_stays_low", 32'(c_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
